interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 169 ++++++++++++++++
 tb/tb_interrupt_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Four-source interrupt controller: two synchronised external inputs, two timer
// inputs, a small register bank and a req/ack/done handshake towards the CPU.
module interrupt_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        int_ext1,
    input  logic        int_ext2,
    input  logic        tim1_irq,
    input  logic        tim2_irq,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [31:0] bus_rdata,
    output logic        irq_req,
    output logic [1:0]  irq_cause,
    input  logic        irq_ack,
    input  logic        irq_done
);
    localparam int SN = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {IDLE = 2'd0, REQUEST = 2'd1, SERVICE = 2'd2} state_t;

    function automatic logic [1:0] prio_enc(input logic [3:0] vec);
        logic [1:0] idx;
        if (vec[0])      idx = 2'd0;
        else if (vec[1]) idx = 2'd1;
        else if (vec[2]) idx = 2'd2;
        else             idx = 2'd3;
        return idx;
    endfunction

    state_t        state_q, state_d;
    logic [SN-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]    hist_q, hist_d;
    logic [3:0]    en_q, en_d, pend_q, pend_d;
    logic          glob_q, glob_d;
    logic          req_q, req_d, insvc_q, insvc_d;
    logic [1:0]    cause_q, cause_d;
    logic [31:0]   rdata_q, rdata_d, rd_mux_s;
    logic [3:0]    set_s, elig_s, w1c_s, ack_clr_s;
    logic [1:0]    ext_rise_s;
    logic          unused_wdata_s;

    assign sync1_d        = {sync1_q[SN-2:0], int_ext1};
    assign sync2_d        = {sync2_q[SN-2:0], int_ext2};
    assign hist_d         = {sync2_q[SN-1], sync1_q[SN-1]};
    assign ext_rise_s     = {sync2_q[SN-1] & ~hist_q[1], sync1_q[SN-1] & ~hist_q[0]};
    assign set_s          = {tim2_irq, tim1_irq, ext_rise_s};
    assign elig_s         = pend_q & en_q & {4{glob_q}};
    assign unused_wdata_s = ^bus_wdata[31:4];

    assign bus_rdata = rdata_q;
    assign irq_req   = req_q;
    assign irq_cause = cause_q;

    // Handshake FSM: request, acknowledge/withdraw, service, return.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        cause_d   = cause_q;
        insvc_d   = insvc_q;
        ack_clr_s = 4'b0000;
        case (state_q)
            IDLE: begin
                if (|elig_s) begin
                    state_d = REQUEST;
                    req_d   = 1'b1;
                    cause_d = prio_enc(elig_s);
                end else begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            REQUEST: begin
                if (irq_ack) begin
                    state_d   = SERVICE;
                    req_d     = 1'b0;
                    insvc_d   = 1'b1;
                    ack_clr_s = 4'b0001 << cause_q;
                end else if (!elig_s[cause_q]) begin
                    // The latched source lost eligibility: withdraw, keep PENDING.
                    state_d = IDLE;
                    req_d   = 1'b0;
                end else begin
                    state_d = REQUEST;
                end
            end
            SERVICE: begin
                if (irq_done) begin
                    state_d = IDLE;
                    insvc_d = 1'b0;
                end else begin
                    state_d = SERVICE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                insvc_d = 1'b0;
            end
        endcase
    end

    // Read-data multiplexer; unused bits read as zero.
    always_comb begin
        case (bus_addr)
            2'd0:    rd_mux_s = {28'd0, en_q};
            2'd1:    rd_mux_s = {28'd0, pend_q};
            2'd2:    rd_mux_s = {27'd0, insvc_q, 2'b00, cause_q};
            2'd3:    rd_mux_s = {31'd0, glob_q};
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Register writes, pending update (a set beats any clear) and read capture.
    always_comb begin
        en_d   = en_q;
        glob_d = glob_q;
        w1c_s  = 4'b0000;
        if (bus_we) begin
            case (bus_addr)
                2'd0:    en_d   = bus_wdata[3:0];
                2'd1:    w1c_s  = bus_wdata[3:0];
                2'd3:    glob_d = bus_wdata[0];
                default: en_d   = en_q;
            endcase
        end else begin
            en_d = en_q;
        end
        pend_d = (pend_q & ~(w1c_s | ack_clr_s)) | set_s;
        if (bus_re) begin
            rdata_d = rd_mux_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sync1_q <= {SN{1'b0}};
            sync2_q <= {SN{1'b0}};
            hist_q  <= 2'b00;
            en_q    <= 4'b0000;
            pend_q  <= 4'b0000;
            glob_q  <= 1'b0;
            req_q   <= 1'b0;
            cause_q <= 2'd0;
            insvc_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            en_q    <= en_d;
            pend_q  <= pend_d;
            glob_q  <= glob_d;
            req_q   <= req_d;
            cause_q <= cause_d;
            insvc_q <= insvc_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller (SYNC_STAGES = 2).
module tb_interrupt_controller;
    logic        clk;
    logic        reset;
    logic        int_ext1, int_ext2, tim1_irq, tim2_irq;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we, bus_re;
    logic [31:0] bus_rdata;
    logic        irq_req;
    logic [1:0]  irq_cause;
    logic        irq_ack, irq_done;

    int vectors;
    int miscompares;

    interrupt_controller #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .int_ext1(int_ext1), .int_ext2(int_ext2),
        .tim1_irq(tim1_irq), .tim2_irq(tim2_irq),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata),
        .irq_req(irq_req), .irq_cause(irq_cause),
        .irq_ack(irq_ack), .irq_done(irq_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_addr = a; bus_wdata = d; bus_we = 1'b1;
        tick();
        bus_we = 1'b0; bus_wdata = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus_addr = a; bus_re = 1'b1;
        tick();
        bus_re = 1'b0;
        d = bus_rdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        do_reset();
        vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", irq_req); end
        vectors++; if (irq_cause !== 2'd0) begin miscompares++; $display("FAIL rst_cause: got %0d want 0", irq_cause); end
        vectors++; if (bus_rdata !== 32'd0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", bus_rdata); end
        for (int a = 0; a < 4; a++) begin
            bus_read(a[1:0], rd);
            vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL rst_reg%0d: got %h want 0", a, rd); end
        end
    endtask

    task automatic test_single_ext();
        logic [31:0] rd;
        do_reset();
        bus_write(2'd0, 32'h1);
        bus_write(2'd3, 32'h1);
        int_ext1 = 1'b1; tick(); int_ext1 = 1'b0;
        tick();
        bus_read(2'd1, rd);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL ext_latency_early: got %h want 0", rd); end
        vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL ext_req_early: got %b want 0", irq_req); end
        bus_read(2'd1, rd);
        vectors++; if (rd !== 32'h1) begin miscompares++; $display("FAIL ext_pending: got %h want 1", rd); end
        vectors++; if (irq_req !== 1'b1) begin miscompares++; $display("FAIL ext_req: got %b want 1", irq_req); end
        vectors++; if (irq_cause !== 2'd0) begin miscompares++; $display("FAIL ext_cause: got %0d want 0", irq_cause); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL ext_ack_req: got %b want 0", irq_req); end
        bus_read(2'd1, rd);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL ext_ack_pend: got %h want 0", rd); end
        bus_read(2'd2, rd);
        vectors++; if (rd !== 32'h10) begin miscompares++; $display("FAIL ext_status_svc: got %h want 10", rd); end
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        bus_read(2'd2, rd);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL ext_status_done: got %h want 0", rd); end
        vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL ext_req_done: got %b want 0", irq_req); end
    endtask

    task automatic test_priority();
        logic [31:0] rd;
        do_reset();
        bus_write(2'd0, 32'hF);
        bus_write(2'd3, 32'h1);
        tim1_irq = 1'b1; tim2_irq = 1'b1; tick(); tim1_irq = 1'b0; tim2_irq = 1'b0;
        tick();
        vectors++; if (irq_req !== 1'b1) begin miscompares++; $display("FAIL prio_req: got %b want 1", irq_req); end
        vectors++; if (irq_cause !== 2'd2) begin miscompares++; $display("FAIL prio_cause: got %0d want 2", irq_cause); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL prio_ack_req: got %b want 0", irq_req); end
        bus_read(2'd1, rd);
        vectors++; if (rd !== 32'h8) begin miscompares++; $display("FAIL prio_pend: got %h want 8", rd); end
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL prio_gap: got %b want 0", irq_req); end
        tick();
        vectors++; if (irq_req !== 1'b1) begin miscompares++; $display("FAIL prio_req2: got %b want 1", irq_req); end
        vectors++; if (irq_cause !== 2'd3) begin miscompares++; $display("FAIL prio_cause2: got %0d want 3", irq_cause); end
    endtask

    task automatic test_withdraw();
        logic [31:0] rd;
        do_reset();
        bus_write(2'd0, 32'h4);
        bus_write(2'd3, 32'h1);
        tim1_irq = 1'b1; tick(); tim1_irq = 1'b0;
        tick();
        vectors++; if (irq_req !== 1'b1) begin miscompares++; $display("FAIL wd_req: got %b want 1", irq_req); end
        bus_write(2'd0, 32'h0);
        tick();
        vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL wd_drop: got %b want 0", irq_req); end
        bus_read(2'd1, rd);
        vectors++; if (rd !== 32'h4) begin miscompares++; $display("FAIL wd_pend: got %h want 4", rd); end
        bus_read(2'd2, rd);
        vectors++; if (rd !== 32'h2) begin miscompares++; $display("FAIL wd_status: got %h want 2", rd); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        bus_read(2'd1, rd);
        vectors++; if (rd !== 32'h4) begin miscompares++; $display("FAIL idle_ack_ignored: got %h want 4", rd); end
    endtask

    task automatic test_race();
        logic [31:0] rd;
        do_reset();
        tim2_irq = 1'b1; tick(); tim2_irq = 1'b0;
        bus_read(2'd1, rd);
        vectors++; if (rd !== 32'h8) begin miscompares++; $display("FAIL race_pre: got %h want 8", rd); end
        bus_addr = 2'd1; bus_wdata = 32'h8; bus_we = 1'b1; tim2_irq = 1'b1;
        tick();
        bus_we = 1'b0; bus_wdata = 32'd0; tim2_irq = 1'b0;
        bus_read(2'd1, rd);
        vectors++; if (rd !== 32'h8) begin miscompares++; $display("FAIL race_set_wins: got %h want 8", rd); end
        bus_write(2'd1, 32'h8);
        bus_read(2'd1, rd);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL race_w1c: got %h want 0", rd); end
        tim2_irq = 1'b1; tick(); tick(); tick(); tim2_irq = 1'b0;
        bus_write(2'd1, 32'h8);
        bus_read(2'd1, rd);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL level_single_clear: got %h want 0", rd); end
    endtask

    task automatic test_no_nesting();
        logic [31:0] rd;
        do_reset();
        bus_write(2'd0, 32'h3);
        bus_write(2'd3, 32'h1);
        int_ext2 = 1'b1; tick(); int_ext2 = 1'b0;
        tick(); tick(); tick();
        vectors++; if (irq_req !== 1'b1) begin miscompares++; $display("FAIL nest_req: got %b want 1", irq_req); end
        vectors++; if (irq_cause !== 2'd1) begin miscompares++; $display("FAIL nest_cause: got %0d want 1", irq_cause); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        int_ext1 = 1'b1; tick(); int_ext1 = 1'b0;
        tick(); tick(); tick();
        vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL nest_blocked: got %b want 0", irq_req); end
        bus_read(2'd1, rd);
        vectors++; if (rd !== 32'h1) begin miscompares++; $display("FAIL nest_pend: got %h want 1", rd); end
        bus_read(2'd2, rd);
        vectors++; if (rd !== 32'h11) begin miscompares++; $display("FAIL nest_status: got %h want 11", rd); end
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        tick();
        vectors++; if (irq_req !== 1'b1) begin miscompares++; $display("FAIL nest_next_req: got %b want 1", irq_req); end
        vectors++; if (irq_cause !== 2'd0) begin miscompares++; $display("FAIL nest_next_cause: got %0d want 0", irq_cause); end
    endtask

    task automatic test_reset_service();
        logic [31:0] rd;
        do_reset();
        bus_write(2'd0, 32'hF);
        bus_write(2'd3, 32'h1);
        tim1_irq = 1'b1; tick(); tim1_irq = 1'b0;
        tick();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        tim2_irq = 1'b1; tick(); tim2_irq = 1'b0;
        do_reset();
        vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL rsvc_req: got %b want 0", irq_req); end
        vectors++; if (irq_cause !== 2'd0) begin miscompares++; $display("FAIL rsvc_cause: got %0d want 0", irq_cause); end
        for (int a = 0; a < 4; a++) begin
            bus_read(a[1:0], rd);
            vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL rsvc_reg%0d: got %h want 0", a, rd); end
        end
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        bus_read(2'd2, rd);
        vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL rsvc_done_status: got %h want 0", rd); end
        vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL rsvc_done_req: got %b want 0", irq_req); end
    endtask

    task automatic test_ext_at_reset();
        logic [31:0] rd;
        int_ext1 = 1'b1;
        do_reset();
        tick(); tick();
        bus_read(2'd1, rd);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL rel_early: got %h want 0", rd); end
        bus_read(2'd1, rd);
        vectors++; if (rd !== 32'h1) begin miscompares++; $display("FAIL rel_pend: got %h want 1", rd); end
        bus_write(2'd1, 32'h1);
        tick(); tick();
        bus_read(2'd1, rd);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL rel_single_event: got %h want 0", rd); end
        int_ext1 = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1;
        int_ext1 = 1'b0; int_ext2 = 1'b0; tim1_irq = 1'b0; tim2_irq = 1'b0;
        bus_addr = 2'd0; bus_wdata = 32'd0; bus_we = 1'b0; bus_re = 1'b0;
        irq_ack = 1'b0; irq_done = 1'b0;
        test_reset();
        test_single_ext();
        test_priority();
        test_withdraw();
        test_race();
        test_no_nesting();
        test_reset_service();
        test_ext_at_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
